// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// quad_step_decoder : quadrature A/B phases -> counter enable/up_down steps
// Revision 1.0 - initial release
// ============================================================================
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int COUNT_MODE  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic clear_err,
    output logic enable,
    output logic up_down,
    output logic error
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] C_FLT_LAST  = 4'(FILTER_LEN - 1);
    localparam logic [2:0] C_INIT_LAST = 3'(SYNC_STAGES);
    localparam bit         C_X1        = (COUNT_MODE == 1);

    state_t     state_q, state_d;
    logic [2:0] init_cnt_q, init_cnt_d;
    logic       init_done;
    logic [1:0] raw_ab;
    logic [1:0] sync_ab;
    logic [1:0] filt_ab;
    logic [1:0] cur_ab_q, cur_ab_d;
    logic [1:0] prev_ab_q, prev_ab_d;
    logic       enable_q, enable_d;
    logic       up_down_q, up_down_d;
    logic       error_q, error_d;
    logic       step_fwd, step_rev, step_bad;

    // Forward Gray successor of an {A,B} code: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] gray_next(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_next = 2'b10;
            2'b10:   gray_next = 2'b11;
            2'b11:   gray_next = 2'b01;
            default: gray_next = 2'b00;
        endcase
    endfunction

    assign raw_ab    = {enc_a, enc_b};
    // The synchronizer chain is full only after SYNC_STAGES edges, so the
    // reference is loaded one cycle later from a fully settled last stage.
    assign init_done = (state_q == ST_INIT) && (init_cnt_q == C_INIT_LAST);

    generate
        for (genvar p = 0; p < 2; p++) begin : g_phase
            logic [SYNC_STAGES-1:0] sync_q;
            logic [3:0]             cnt_q, cnt_d;
            logic                   filt_q, filt_d;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q <= '0;
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], raw_ab[p]};
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            always_comb begin
                cnt_d  = cnt_q;
                filt_d = filt_q;
                if (state_q == ST_INIT) begin
                    cnt_d = '0;
                    if (init_done) begin
                        filt_d = sync_q[SYNC_STAGES-1];
                    end
                end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == C_FLT_LAST) begin
                    cnt_d  = '0;
                    filt_d = sync_q[SYNC_STAGES-1];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            assign sync_ab[p] = sync_q[SYNC_STAGES-1];
            assign filt_ab[p] = filt_q;
        end
    endgenerate

    assign step_fwd = (cur_ab_q == gray_next(prev_ab_q));
    assign step_rev = (prev_ab_q == gray_next(cur_ab_q));
    assign step_bad = ((cur_ab_q ^ prev_ab_q) == 2'b11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            cur_ab_q   <= '0;
            prev_ab_q  <= '0;
            enable_q   <= 1'b0;
            up_down_q  <= 1'b1;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            cur_ab_q   <= cur_ab_d;
            prev_ab_q  <= prev_ab_d;
            enable_q   <= enable_d;
            up_down_q  <= up_down_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cur_ab_d   = cur_ab_q;
        prev_ab_d  = prev_ab_q;
        enable_d   = 1'b0;
        up_down_d  = up_down_q;
        error_d    = error_q;
        if (clear_err) begin
            error_d = 1'b0;
        end
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 3'd1;
                if (init_done) begin
                    state_d   = ST_RUN;
                    cur_ab_d  = sync_ab;
                    prev_ab_d = sync_ab;
                end
            end
            default: begin
                cur_ab_d  = filt_ab;
                prev_ab_d = cur_ab_q;
                if (step_fwd || step_rev) begin
                    enable_d  = !C_X1 || (cur_ab_q == 2'b00);
                    up_down_d = step_fwd;
                end
                // An illegal step overrides a concurrent clear request
                if (step_bad) begin
                    error_d = 1'b1;
                end
            end
        endcase
    end

    assign enable  = enable_q;
    assign up_down = up_down_q;
    assign error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// tb_quad_step_decoder : scoreboard bench for x4 and x1 decoder instances
// Revision 1.0 - initial release
// ============================================================================
module tb_quad_step_decoder;

    typedef struct packed {
        int   cyc;
        logic dir;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic clear_err = 1'b0;
    logic en0, ud0, er0;
    logic en1, ud1, er1;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   p1_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic [1:0] m_ab = 2'b00;
    logic       m_ud = 1'b1;

    quad_step_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4), .COUNT_MODE(4)) dut0 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .clear_err(clear_err), .enable(en0), .up_down(ud0), .error(er0)
    );

    quad_step_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4), .COUNT_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .clear_err(clear_err), .enable(en1), .up_down(ud1), .error(er1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [1:0] fwd_of(input logic [1:0] ab);
        case (ab)
            2'b00:   fwd_of = 2'b10;
            2'b10:   fwd_of = 2'b11;
            2'b11:   fwd_of = 2'b01;
            default: fwd_of = 2'b00;
        endcase
    endfunction

    // Pulse comparator: every enable must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        if (en0 === 1'b1) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL pulse_x4: unexpected enable at cycle %0d", cyc);
            end else begin
                e = q0.pop_front();
                if (e.cyc != cyc || ud0 !== e.dir) begin
                    n_err++;
                    $display("FAIL pulse_x4: cycle %0d up_down %b, required cycle %0d up_down %b",
                             cyc, ud0, e.cyc, e.dir);
                end
            end
        end else if (q0.size() != 0 && q0[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL pulse_x4: missing enable due at cycle %0d (now %0d)", q0[0].cyc, cyc);
            void'(q0.pop_front());
        end
        if (en1 === 1'b1) begin
            n_vec++;
            p1_cnt++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL pulse_x1: unexpected enable at cycle %0d", cyc);
            end else begin
                e = q1.pop_front();
                if (e.cyc != cyc || ud1 !== e.dir) begin
                    n_err++;
                    $display("FAIL pulse_x1: cycle %0d up_down %b, required cycle %0d up_down %b",
                             cyc, ud1, e.cyc, e.dir);
                end
            end
        end else if (q1.size() != 0 && q1[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL pulse_x1: missing enable due at cycle %0d (now %0d)", q1[0].cyc, cyc);
            void'(q1.pop_front());
        end
    end

    // Called on a negedge: applies a new AB level, predicts pulses, holds.
    task automatic drive_ab(input logic [1:0] ab, input int hold);
        exp_t e;
        logic fwd, rev;
        fwd = (ab == fwd_of(m_ab));
        rev = (m_ab == fwd_of(ab));
        enc_a = ab[1];
        enc_b = ab[0];
        if (fwd || rev) begin
            e.cyc = cyc + 8;
            e.dir = fwd;
            q0.push_back(e);
            if (ab == 2'b00) q1.push_back(e);
            m_ud = fwd;
        end
        m_ab = ab;
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending: %0d/%0d pulses outstanding, required 0/0",
                     name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        n_vec++;
        if (ud0 !== m_ud || ud1 !== m_ud || er0 !== 1'b0 || er1 !== 1'b0) begin
            n_err++;
            $display("FAIL %s_state: up_down %b/%b error %b/%b, required up_down %b error 0",
                     name, ud0, ud1, er0, er1, m_ud);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (en0 !== 1'b0 || ud0 !== 1'b1 || er0 !== 1'b0 ||
            en1 !== 1'b0 || ud1 !== 1'b1 || er1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: en %b%b ud %b%b err %b%b, required en 00 ud 11 err 00",
                     en0, en1, ud0, ud1, er0, er1);
        end
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check_idle("reset");
    endtask

    task automatic test_forward();
        @(negedge clk);
        drive_ab(2'b10, 10);
        drive_ab(2'b11, 10);
        drive_ab(2'b01, 10);
        drive_ab(2'b00, 12);
        check_idle("forward");
    endtask

    task automatic test_reverse();
        @(negedge clk);
        drive_ab(2'b01, 10);
        drive_ab(2'b11, 10);
        drive_ab(2'b10, 10);
        drive_ab(2'b00, 12);
        check_idle("reverse");
    endtask

    task automatic test_glitch();
        @(negedge clk);
        enc_a = 1'b1;
        repeat (3) @(negedge clk);
        enc_a = 1'b0;
        repeat (14) @(negedge clk);
        check_idle("glitch3");
        // Exactly FILTER_LEN cycles high: rise then fall, minimum spacing
        drive_ab(2'b10, 4);
        drive_ab(2'b00, 14);
        check_idle("glitch4");
    endtask

    task automatic test_illegal();
        @(negedge clk);
        drive_ab(2'b11, 12);
        n_vec++;
        if (er0 !== 1'b1 || er1 !== 1'b1 || ud0 !== m_ud || ud1 !== m_ud) begin
            n_err++;
            $display("FAIL illegal_set: error %b/%b up_down %b/%b, required error 1 up_down %b",
                     er0, er1, ud0, ud1, m_ud);
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (er0 !== 1'b0 || er1 !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_clear: error %b/%b, required 0", er0, er1);
        end
        // Second illegal step whose decode cycle coincides with clear_err
        drive_ab(2'b00, 7);
        clear_err = 1'b1;
        @(negedge clk);
        n_vec++;
        if (er0 !== 1'b1 || er1 !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_set_wins: error %b/%b, required 1", er0, er1);
        end
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (er0 !== 1'b1 || er1 !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_sticky: error %b/%b, required 1", er0, er1);
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("illegal");
    endtask

    task automatic test_x1();
        @(negedge clk);
        p1_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            drive_ab(2'b10, 10);
            drive_ab(2'b11, 10);
            drive_ab(2'b01, 10);
            drive_ab(2'b00, 12);
        end
        n_vec++;
        if (p1_cnt != 2) begin
            n_err++;
            $display("FAIL x1_count: %0d pulses, required 2", p1_cnt);
        end
        check_idle("x1");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_ab(2'b01, 10);
        drive_ab(2'b11, 12);
        check_idle("pre_reset");
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (en0 !== 1'b0 || ud0 !== 1'b1 || er0 !== 1'b0 ||
            en1 !== 1'b0 || ud1 !== 1'b1 || er1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: en %b%b ud %b%b err %b%b, required en 00 ud 11 err 00",
                     en0, en1, ud0, ud1, er0, er1);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_ud = 1'b1;
        repeat (15) @(negedge clk);
        check_idle("post_reset");
        drive_ab(2'b01, 12);
        check_idle("after_reset_step");
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_x1();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
